bit_serializer: RTL and testbench

//  Upstream stage of the serial-input FSMs: takes parallel words through a

---
 rtl/bit_serializer.sv | 184 ++++++++++++++++++
 tb/tb_bit_serializer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// ----------------------------------------------------------------------------
// bit_serializer
//
// Purpose:
//   Accepts parallel words through a valid/ready handshake and shifts them out
//   one bit per clock on x. A single holding register lets the next word be
//   accepted while the current word is still shifting. After the last bit of
//   each word a programmable number of idle cycles is inserted.
//
// Parameters:
//   WIDTH       bits per word (>= 2)
//   GAP_CYCLES  idle cycles after each word's last bit (0 = back-to-back)
//   LSB_FIRST   0: MSB shifted first, 1: LSB shifted first
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous reset, active-low
//   din        parallel word to serialize
//   din_valid  din holds a word
//   din_ready  holding register empty; word accepted when valid & ready
//   x          serial data bit (registered, 0 whenever x_valid is 0)
//   x_valid    x carries a data bit this cycle (registered)
//   last_bit   high together with the final bit of each word (registered)
//   busy       serializer not idle or holding register full
// ----------------------------------------------------------------------------
module bit_serializer #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 1,
    parameter int LSB_FIRST  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             last_bit,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic             take_hold;
    logic             reload;
    logic             accept;
    logic [WIDTH-1:0] shifter;
    logic [WIDTH-1:0] shifter_next;
    logic [CW-1:0]    bit_cnt;
    logic [CW-1:0]    bit_cnt_next;
    logic [GW-1:0]    gap_cnt;
    logic [GW-1:0]    gap_cnt_next;
    logic             x_next;
    logic             x_valid_next;
    logic             last_bit_next;

    // The bit that goes out first from a word, and what remains afterwards.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return (LSB_FIRST != 0) ? w[0] : w[WIDTH-1];
    endfunction

    function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] w);
        return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
    endfunction

    assign din_ready = ~hold_full;
    assign accept    = din_valid & din_ready;
    assign busy      = (state != IDLE) | hold_full;

    // Holding register. Accept and hand-over to the shifter can never collide:
    // accepting needs the register empty, handing over needs it full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (accept) begin
            hold      <= din;
            hold_full <= 1'b1;
        end else if (take_hold) begin
            hold_full <= 1'b0;
        end
    end

    // Next-state logic. The serial outputs are registered, so this computes
    // the values x/x_valid/last_bit will show after the coming edge. The
    // shifter holds only the bits not yet presented on x; bit_cnt is the index
    // of the bit currently on x.
    always_comb begin
        state_next    = state;
        shifter_next  = shifter;
        bit_cnt_next  = bit_cnt;
        gap_cnt_next  = gap_cnt;
        take_hold     = 1'b0;
        reload        = 1'b0;
        x_next        = 1'b0;
        x_valid_next  = 1'b0;
        last_bit_next = 1'b0;

        case (state)
            IDLE: begin
                if (hold_full) begin
                    reload = 1'b1;
                end
            end
            SHIFT: begin
                if (bit_cnt != BIT_LAST) begin
                    x_next        = head_bit(shifter);
                    x_valid_next  = 1'b1;
                    shifter_next  = drop_head(shifter);
                    bit_cnt_next  = bit_cnt + 1'b1;
                    last_bit_next = (bit_cnt_next == BIT_LAST);
                end else if (GAP_CYCLES > 0) begin
                    state_next   = GAP;
                    gap_cnt_next = '0;
                end else if (hold_full) begin
                    reload = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    if (hold_full) begin
                        reload = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    gap_cnt_next = gap_cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Start a new word straight from the holding register: its first bit
        // appears on x right after this edge.
        if (reload) begin
            take_hold     = 1'b1;
            state_next    = SHIFT;
            shifter_next  = drop_head(hold);
            bit_cnt_next  = '0;
            x_next        = head_bit(hold);
            x_valid_next  = 1'b1;
            last_bit_next = 1'b0;
        end
    end

    // State, counters, shifter and the registered serial outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            shifter  <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            x        <= 1'b0;
            x_valid  <= 1'b0;
            last_bit <= 1'b0;
        end else begin
            state    <= state_next;
            shifter  <= shifter_next;
            bit_cnt  <= bit_cnt_next;
            gap_cnt  <= gap_cnt_next;
            x        <= x_next;
            x_valid  <= x_valid_next;
            last_bit <= last_bit_next;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// ----------------------------------------------------------------------------
// tb_bit_serializer
//
// Purpose:
//   Self-checking bench for bit_serializer. Three instances share clock and
//   reset: the default configuration (MSB first, one gap cycle), a
//   back-to-back configuration (no gap), and an LSB-first configuration with a
//   two-cycle gap. Inputs are driven and outputs sampled on the falling edge,
//   so "after edge k" below means the falling edge following rising edge k.
//
// Ports:
//   none (top-level bench)
// ----------------------------------------------------------------------------
module tb_bit_serializer;

    logic       clk;
    logic       rst;

    logic [7:0] din_a;
    logic       din_valid_a;
    logic       din_ready_a;
    logic       x_a;
    logic       x_valid_a;
    logic       last_bit_a;
    logic       busy_a;

    logic [7:0] din_g;
    logic       din_valid_g;
    logic       din_ready_g;
    logic       x_g;
    logic       x_valid_g;
    logic       last_bit_g;
    logic       busy_g;

    logic [7:0] din_l;
    logic       din_valid_l;
    logic       din_ready_l;
    logic       x_l;
    logic       x_valid_l;
    logic       last_bit_l;
    logic       busy_l;

    int checks;
    int failures;

    bit_serializer #(.WIDTH(8), .GAP_CYCLES(1), .LSB_FIRST(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din_a),
        .din_valid (din_valid_a),
        .din_ready (din_ready_a),
        .x         (x_a),
        .x_valid   (x_valid_a),
        .last_bit  (last_bit_a),
        .busy      (busy_a)
    );

    bit_serializer #(.WIDTH(8), .GAP_CYCLES(0), .LSB_FIRST(0)) dut_g0 (
        .clk       (clk),
        .rst       (rst),
        .din       (din_g),
        .din_valid (din_valid_g),
        .din_ready (din_ready_g),
        .x         (x_g),
        .x_valid   (x_valid_g),
        .last_bit  (last_bit_g),
        .busy      (busy_g)
    );

    bit_serializer #(.WIDTH(8), .GAP_CYCLES(2), .LSB_FIRST(1)) dut_lsb (
        .clk       (clk),
        .rst       (rst),
        .din       (din_l),
        .din_valid (din_valid_l),
        .din_ready (din_ready_l),
        .x         (x_l),
        .x_valid   (x_valid_l),
        .last_bit  (last_bit_l),
        .busy      (busy_l)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Asynchronous reset: outputs must clear without a clock edge, and a word
    // that was shifting plus one that was held must both vanish.
    task automatic test_reset();
        logic [4:0] obs;
        #2 rst = 1'b0;
        #1;
        obs = {x_valid_a, x_a, last_bit_a, busy_a, din_ready_a};
        checks++;
        if (obs !== 5'b00001) begin
            failures++;
            $display("[TB] FAIL reset_initial got %b exp %b", obs, 5'b00001);
        end
        @(negedge clk);
        rst         = 1'b1;
        din_a       = 8'hC3;
        din_valid_a = 1'b1;
        @(negedge clk);
        din_a = 8'h3C;
        @(negedge clk);
        @(negedge clk);
        din_valid_a = 1'b0;
        obs = {x_valid_a, x_a, last_bit_a, busy_a, din_ready_a};
        checks++;
        if (obs !== 5'b11010) begin
            failures++;
            $display("[TB] FAIL reset_midword_pre got %b exp %b", obs, 5'b11010);
        end
        #2 rst = 1'b0;
        #1;
        obs = {x_valid_a, x_a, last_bit_a, busy_a, din_ready_a};
        checks++;
        if (obs !== 5'b00001) begin
            failures++;
            $display("[TB] FAIL reset_async got %b exp %b", obs, 5'b00001);
        end
        #1 rst = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            obs = {x_valid_a, x_a, last_bit_a, busy_a, din_ready_a};
            checks++;
            if (obs !== 5'b00001) begin
                failures++;
                $display("[TB] FAIL reset_residual k=%0d got %b exp %b", k, obs, 5'b00001);
            end
        end
    endtask

    // One word 8'hA5, MSB first, one gap cycle, then back to idle.
    task automatic test_single();
        logic [1:11] e_xv;
        logic [1:11] e_x;
        logic [1:11] e_lb;
        logic [1:11] e_busy;
        logic [1:11] e_rdy;
        logic [4:0]  obs;
        logic [4:0]  exp;
        e_xv   = 11'b0_11111111_00;
        e_x    = 11'b0_10100101_00;
        e_lb   = 11'b0_00000001_00;
        e_busy = 11'b1111111111_0;
        e_rdy  = 11'b0_1111111111;
        din_a       = 8'hA5;
        din_valid_a = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 1) din_valid_a = 1'b0;
            obs = {x_valid_a, x_a, last_bit_a, busy_a, din_ready_a};
            exp = {e_xv[k], e_x[k], e_lb[k], e_busy[k], e_rdy[k]};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("[TB] FAIL single k=%0d got %b exp %b", k, obs, exp);
            end
        end
    endtask

    // 8'hF0 then 8'h0F; the second word waits in the holding register while
    // the first shifts, and follows after one gap cycle.
    task automatic test_back_to_back();
        logic [1:20] e_xv;
        logic [1:20] e_x;
        logic [1:20] e_lb;
        logic [1:20] e_busy;
        logic [1:20] e_rdy;
        logic [4:0]  obs;
        logic [4:0]  exp;
        e_xv   = 20'b0_11111111_0_11111111_00;
        e_x    = 20'b0_11110000_0_00001111_00;
        e_lb   = 20'b0_00000001_0_00000001_00;
        e_busy = 20'b1111111111111111111_0;
        e_rdy  = 20'b0_1_00000000_1111111111;
        din_a       = 8'hF0;
        din_valid_a = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) din_a = 8'h0F;
            if (k == 3) din_valid_a = 1'b0;
            obs = {x_valid_a, x_a, last_bit_a, busy_a, din_ready_a};
            exp = {e_xv[k], e_x[k], e_lb[k], e_busy[k], e_rdy[k]};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("[TB] FAIL back_to_back k=%0d got %b exp %b", k, obs, exp);
            end
        end
    endtask

    // No gap: 8'hFF then 8'h00 give 16 contiguous valid bits.
    task automatic test_gap_zero();
        logic [1:18] e_xv;
        logic [1:18] e_x;
        logic [1:18] e_lb;
        logic [1:18] e_busy;
        logic [1:18] e_rdy;
        logic [4:0]  obs;
        logic [4:0]  exp;
        e_xv   = 18'b0_1111111111111111_0;
        e_x    = 18'b0_11111111_00000000_0;
        e_lb   = 18'b0_00000001_00000001_0;
        e_busy = 18'b11111111111111111_0;
        e_rdy  = 18'b0_1_0000000_111111111;
        din_g       = 8'hFF;
        din_valid_g = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k == 1) din_g = 8'h00;
            if (k == 3) din_valid_g = 1'b0;
            obs = {x_valid_g, x_g, last_bit_g, busy_g, din_ready_g};
            exp = {e_xv[k], e_x[k], e_lb[k], e_busy[k], e_rdy[k]};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("[TB] FAIL gap_zero k=%0d got %b exp %b", k, obs, exp);
            end
        end
    endtask

    // LSB first with a two-cycle gap: 8'h01 then 8'h80.
    task automatic test_lsb_first();
        logic [1:22] e_xv;
        logic [1:22] e_x;
        logic [1:22] e_lb;
        logic [1:22] e_busy;
        logic [1:22] e_rdy;
        logic [4:0]  obs;
        logic [4:0]  exp;
        e_xv   = 22'b0_11111111_00_11111111_000;
        e_x    = 22'b0_10000000_00_00000001_000;
        e_lb   = 22'b0_00000001_00_00000001_000;
        e_busy = 22'b111111111111111111111_0;
        e_rdy  = 22'b0_1_000000000_11111111111;
        din_l       = 8'h01;
        din_valid_l = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (k == 1) din_l = 8'h80;
            if (k == 3) din_valid_l = 1'b0;
            obs = {x_valid_l, x_l, last_bit_l, busy_l, din_ready_l};
            exp = {e_xv[k], e_x[k], e_lb[k], e_busy[k], e_rdy[k]};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("[TB] FAIL lsb_first k=%0d got %b exp %b", k, obs, exp);
            end
        end
    endtask

    // 200 words with random valid bursts; every emitted bit is matched against
    // a queue of expected bits built from the accepted words.
    task automatic test_random();
        logic exp_q[$];
        logic exp_bit;
        logic will_acc;
        int   words_in;
        int   bits_out;
        int   pos;
        int   cyc;
        words_in    = 0;
        bits_out    = 0;
        pos         = 0;
        cyc         = 0;
        will_acc    = 1'b0;
        din_valid_a = 1'b0;
        while ((words_in < 200 || exp_q.size() > 0 || busy_a) && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            if (x_valid_a) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL random_extra got bit %b exp none", x_a);
                end else begin
                    exp_bit = exp_q.pop_front();
                    bits_out++;
                    if (x_a !== exp_bit) begin
                        failures++;
                        $display("[TB] FAIL random_bit n=%0d got %b exp %b", bits_out, x_a, exp_bit);
                    end
                end
                checks++;
                if (last_bit_a !== (pos == 7)) begin
                    failures++;
                    $display("[TB] FAIL random_last pos=%0d got %b exp %b", pos, last_bit_a, (pos == 7));
                end
                pos = (pos == 7) ? 0 : pos + 1;
            end else begin
                checks++;
                if (x_a !== 1'b0 || last_bit_a !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL random_idle got x=%b last=%b exp 0 0", x_a, last_bit_a);
                end
            end
            if (will_acc || !din_valid_a) begin
                if (words_in < 200 && $urandom_range(0, 9) < 6) begin
                    din_a       = 8'($urandom);
                    din_valid_a = 1'b1;
                end else begin
                    din_valid_a = 1'b0;
                end
            end
            will_acc = din_valid_a && din_ready_a;
            if (will_acc) begin
                words_in++;
                for (int i = 7; i >= 0; i--) exp_q.push_back(din_a[i]);
            end
        end
        din_valid_a = 1'b0;
        checks++;
        if (cyc >= 6000 || bits_out != 1600) begin
            failures++;
            $display("[TB] FAIL random_drain got bits=%0d cycles=%0d exp bits=1600 within 6000", bits_out, cyc);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        din_a       = '0;
        din_valid_a = 1'b0;
        din_g       = '0;
        din_valid_g = 1'b0;
        din_l       = '0;
        din_valid_l = 1'b0;

        test_reset();
        test_single();
        test_back_to_back();
        test_gap_zero();
        test_lsb_first();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
